dmem_responder: RTL and testbench

//  Data-memory responder serving the 16-bit pipelined CPU's load/store requests over a

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_array.sv | 28 ++
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 tb/tb_dmem_responder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: widths, word addressing
// and the FSM state encoding.
package dmem_pkg;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int WORD_SHIFT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } dmem_state_e;
endpackage

// File: rtl/dmem_array.sv
// Word storage for the responder: DEPTH x DATA_W, written on the falling
// clock edge, read combinationally. Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store port: one word per falling edge when enabled.
    always_ff @(negedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined CPU's MEM stage. Accepts one
// load/store at a time, waits WAIT_CYCLES, then presents a response.
//
// Handshake: a transfer happens on a falling clock edge where valid and ready
// are both high. The initiator holds req_* stable while req_valid && !req_ready;
// this block holds rsp_* stable while rsp_valid && !rsp_ready. req_ready is high
// only in IDLE, rsp_valid only in RESP, so a new request is never accepted on
// the same edge a response completes.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output dmem_state_e       dbg_state
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int FULL_IDX_W = ADDR_W - WORD_SHIFT;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    dmem_state_e state, state_next;
    logic [CNT_W-1:0] cnt;

    // Request fields captured at acceptance for use at the commit edge.
    logic              lat_write;
    logic [IDX_W-1:0]  lat_idx;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_err;

    logic accept, commit, use_live;

    // Live decode of the incoming request (word index and bad-address check).
    logic [FULL_IDX_W-1:0] req_full_idx;
    logic [IDX_W-1:0]      req_idx;
    logic                  req_err;

    assign req_full_idx = req_addr[ADDR_W-1:WORD_SHIFT];
    assign req_idx      = req_full_idx[IDX_W-1:0];
    assign req_err      = (|req_addr[WORD_SHIFT-1:0])
                        || ((ADDR_W + 1)'(req_full_idx) >= DEPTH_L);

    // Commit operands: the live request when there are no wait states,
    // otherwise the captured copy.
    logic              c_write;
    logic [IDX_W-1:0]  c_idx;
    logic [DATA_W-1:0] c_wdata;
    logic              c_err;
    logic [DATA_W-1:0] rd_data;
    logic              mem_we;

    // Select between live and captured request for the commit.
    always_comb begin
        c_write = lat_write;
        c_idx   = lat_idx;
        c_wdata = lat_wdata;
        c_err   = lat_err;
        if (use_live) begin
            c_write = req_write;
            c_idx   = req_idx;
            c_wdata = req_wdata;
            c_err   = req_err;
        end
    end

    // A reset on the commit edge drops the store.
    assign mem_we = commit && c_write && !c_err && !reset;

    dmem_array #(
        .DEPTH(DEPTH),
        .IDX_W(IDX_W)
    ) u_array (
        .clock(clock),
        .we   (mem_we),
        .waddr(c_idx),
        .wdata(c_wdata),
        .raddr(c_idx),
        .rdata(rd_data)
    );

    // Next-state and handshake decode.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        use_live   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        commit     = 1'b1;
                        use_live   = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    commit     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, wait counter and registered response outputs.
    always_ff @(negedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt <= CNT_W'(WAIT_CYCLES);
            end else if (state == BUSY) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                rsp_err   <= c_err;
                rsp_rdata <= (c_err || c_write) ? '0 : rd_data;
            end else if (rsp_valid && rsp_ready) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Capture the request on acceptance; held until the next acceptance.
    always_ff @(negedge clock) begin
        if (!reset && accept) begin
            lat_write <= req_write;
            lat_idx   <= req_idx;
            lat_wdata <= req_wdata;
            lat_err   <= req_err;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES=2 and 0) driven one at
// a time, an edge-timeline reference model, a per-cycle compare process and
// directed literal checks followed by randomized traffic.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 1024;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic              req_valid [2];
    logic              req_ready [2];
    logic              req_write [2];
    logic [15:0]       req_addr  [2];
    logic [15:0]       req_wdata [2];
    logic              rsp_valid [2];
    logic              rsp_ready [2];
    logic [15:0]       rsp_rdata [2];
    logic              rsp_err   [2];
    dmem_state_e       dbg_state [2];

    int n_cmp  = 0;
    int n_err  = 0;
    bit done   = 1'b0;
    int edge_n = 0;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .dbg_state(dbg_state[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .dbg_state(dbg_state[1])
    );

    function automatic int w_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Transaction timeline per instance: a request accepted at edge E becomes
    // visible at edge E+W, where it also takes effect on memory; it completes at
    // the first later edge with rsp_ready high. Reset discards whatever is open.
    bit          m_live   [2];
    bit          m_out    [2];
    bit          m_shown  [2];
    bit          m_rk     [2];
    bit          m_err    [2];
    logic [15:0] m_rdata  [2];
    int          m_rsp_at [2];
    bit          t_write  [2];
    logic [15:0] t_addr   [2];
    logic [15:0] t_wdata  [2];
    logic [15:0] mmem     [2][DEPTH];
    bit          mknown   [2][DEPTH];

    initial begin
        int idx;
        logic [15:0] a;
        forever begin
            @(negedge clock);
            edge_n++;
            for (int d = 0; d < 2; d++) begin
                if (reset) begin
                    m_live[d]  = 1'b1;
                    m_out[d]   = 1'b0;
                    m_shown[d] = 1'b0;
                    m_rk[d]    = 1'b1;
                    m_err[d]   = 1'b0;
                    m_rdata[d] = 16'h0;
                end else if (m_live[d]) begin
                    if (m_out[d] && m_shown[d] && rsp_ready[d]) begin
                        m_out[d]   = 1'b0;
                        m_shown[d] = 1'b0;
                        m_rk[d]    = 1'b1;
                        m_err[d]   = 1'b0;
                        m_rdata[d] = 16'h0;
                    end else if (!m_out[d] && req_valid[d]) begin
                        m_out[d]    = 1'b1;
                        m_rsp_at[d] = edge_n + w_of(d);
                        t_write[d]  = req_write[d];
                        t_addr[d]   = req_addr[d];
                        t_wdata[d]  = req_wdata[d];
                    end
                    if (m_out[d] && !m_shown[d] && edge_n == m_rsp_at[d]) begin
                        a   = t_addr[d];
                        idx = int'(a[15:1]);
                        if (a[0] || idx >= DEPTH) begin
                            m_err[d] = 1'b1; m_rdata[d] = 16'h0; m_rk[d] = 1'b1;
                        end else if (t_write[d]) begin
                            mmem[d][idx]   = t_wdata[d];
                            mknown[d][idx] = 1'b1;
                            m_err[d] = 1'b0; m_rdata[d] = 16'h0; m_rk[d] = 1'b1;
                        end else begin
                            m_err[d]   = 1'b0;
                            m_rdata[d] = mmem[d][idx];
                            m_rk[d]    = mknown[d][idx];
                        end
                        m_shown[d] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [1:0] es;
        forever begin
            @(posedge clock);
            if (!done) begin
                for (int d = 0; d < 2; d++) begin
                    if (m_live[d]) begin
                        es = m_shown[d] ? 2'b10 : (m_out[d] ? 2'b01 : 2'b00);
                        check($sformatf("req_ready[%0d]", d), 32'(req_ready[d]), 32'(!m_out[d]));
                        check($sformatf("rsp_valid[%0d]", d), 32'(rsp_valid[d]), 32'(m_shown[d]));
                        check($sformatf("rsp_err[%0d]", d), 32'(rsp_err[d]), 32'(m_err[d]));
                        check($sformatf("state[%0d]", d), 32'(dbg_state[d]), 32'(es));
                        if (m_rk[d])
                            check($sformatf("rsp_rdata[%0d]", d), 32'(rsp_rdata[d]), 32'(m_rdata[d]));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a rising edge.
    task automatic do_req(input int d, input bit wr, input logic [15:0] a,
                          input logic [15:0] wd, output int acc);
        int budget;
        budget = 40;
        req_write[d] = wr; req_addr[d] = a; req_wdata[d] = wd; req_valid[d] = 1'b1;
        while (!req_ready[d] && budget > 0) begin
            @(posedge clock); #1;
            budget--;
        end
        if (budget == 0) check("req_accept_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
        acc = edge_n;
        req_valid[d] = 1'b0;
        req_write[d] = 1'($urandom_range(0, 1));
        req_addr[d]  = 16'($urandom);
        req_wdata[d] = 16'($urandom);
    endtask

    task automatic wait_rsp(input int d, input int hold, output logic [15:0] rd,
                            output logic er, output int vis, output int low);
        int budget;
        budget = 40;
        low = 0;
        rsp_ready[d] = (hold == 0);
        while (budget > 0) begin
            if (!req_ready[d]) low++;
            if (rsp_valid[d]) break;
            @(posedge clock); #1;
            budget--;
        end
        if (budget == 0) check("rsp_timeout", 32'd0, 32'd1);
        vis = edge_n;
        rd  = rsp_rdata[d];
        er  = rsp_err[d];
        for (int k = 0; k < hold; k++) begin
            @(posedge clock); #1;
            if (!req_ready[d]) low++;
            check("hold_rsp_valid", 32'(rsp_valid[d]), 32'd1);
            check("hold_req_ready", 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clock); #1;
        check("after_hs_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        check("after_hs_req_ready", 32'(req_ready[d]), 32'd1);
        check("after_hs_state", 32'(dbg_state[d]), 32'(IDLE));
    endtask

    task automatic xact(input int d, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                        input int hold, output logic [15:0] rd, output logic er,
                        output int lat, output int low);
        int acc, vis;
        do_req(d, wr, a, wd, acc);
        wait_rsp(d, hold, rd, er, vis, low);
        lat = vis - acc;
    endtask

    task automatic rand_traffic(input int d, input int n);
        int sel, lat, low, acc, vis, hold;
        logic [15:0] a, rd;
        logic er;
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 16'($urandom_range(0, 15)) << 1;
            else if (sel == 7) a = (16'($urandom_range(0, 15)) << 1) | 16'd1;
            else if (sel == 8) a = 16'($urandom_range(2048, 65535));
            else               a = 16'd2046;
            do_req(d, 1'($urandom_range(0, 1)), a, 16'($urandom), acc);
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b1;
                @(posedge clock); #1;
                reset = 1'b0;
            end else begin
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
                wait_rsp(d, hold, rd, er, vis, low);
                lat = vis - acc;
                check("rand_latency", 32'(lat), 32'(w_of(d)));
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [15:0] rd, rd2;
        logic er;
        int lat, low, acc1, acc2, vis1, vis2;

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0;
            req_addr[d] = 16'h0; req_wdata[d] = 16'h0; rsp_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("reset_req_ready", 32'(req_ready[d]), 32'd1);
            check("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check("reset_rsp_rdata", 32'(rsp_rdata[d]), 32'd0);
            check("reset_rsp_err",   32'(rsp_err[d]),   32'd0);
        end

        // Load from word 0 after seeding it with 5.
        xact(0, 1'b1, 16'd0, 16'd5, 0, rd, er, lat, low);
        xact(0, 1'b0, 16'd0, 16'h0, 0, rd, er, lat, low);
        check("t1_latency", 32'(lat), 32'd2);
        check("t1_rdata", 32'(rd), 32'd5);
        check("t1_err", 32'(er), 32'd0);
        xact(0, 1'b1, 16'd4, 16'h1234, 0, rd, er, lat, low);

        // Store then load the same word.
        xact(0, 1'b1, 16'd2, 16'd7, 0, rd, er, lat, low);
        check("t2_store_rdata", 32'(rd), 32'd0);
        check("t2_store_busy_cycles", 32'(low), 32'd3);
        xact(0, 1'b0, 16'd2, 16'h0, 0, rd, er, lat, low);
        check("t2_load_rdata", 32'(rd), 32'd7);
        check("t2_load_busy_cycles", 32'(low), 32'd3);

        // Bad addresses: misaligned and one past the end.
        xact(0, 1'b0, 16'd3, 16'h0, 0, rd, er, lat, low);
        check("t3_misaligned_err", 32'(er), 32'd1);
        check("t3_misaligned_rdata", 32'(rd), 32'd0);
        xact(0, 1'b0, 16'd2048, 16'h0, 0, rd, er, lat, low);
        check("t3_range_err", 32'(er), 32'd1);
        check("t3_range_rdata", 32'(rd), 32'd0);
        xact(0, 1'b1, 16'd3, 16'hBEEF, 0, rd, er, lat, low);
        check("t3_bad_store_err", 32'(er), 32'd1);
        xact(0, 1'b1, 16'd2048, 16'hBEEF, 0, rd, er, lat, low);
        check("t3_range_store_err", 32'(er), 32'd1);
        xact(0, 1'b0, 16'd2, 16'h0, 0, rd, er, lat, low);
        check("t3_word1_intact", 32'(rd), 32'd7);
        xact(0, 1'b0, 16'd0, 16'h0, 0, rd, er, lat, low);
        check("t3_word0_intact", 32'(rd), 32'd5);

        // Response held for 5 cycles by the initiator.
        xact(0, 1'b0, 16'd4, 16'h0, 5, rd, er, lat, low);
        check("t4_rdata", 32'(rd), 32'h1234);
        check("t4_busy_cycles", 32'(low), 32'd8);

        // Reset while a store of 9 to word 2 is waiting.
        do_req(0, 1'b1, 16'd4, 16'd9, acc1);
        check("t5_in_busy", 32'(dbg_state[0]), 32'(BUSY));
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("t5_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("t5_req_ready", 32'(req_ready[0]), 32'd1);
        xact(0, 1'b0, 16'd4, 16'h0, 0, rd, er, lat, low);
        check("t5_word2_unchanged", 32'(rd), 32'h1234);

        rand_traffic(0, 200);

        // Zero wait states: back-to-back loads.
        xact(1, 1'b1, 16'd0, 16'h00AA, 0, rd, er, lat, low);
        xact(1, 1'b1, 16'd2, 16'h00BB, 0, rd, er, lat, low);
        do_req(1, 1'b0, 16'd0, 16'h0, acc1);
        wait_rsp(1, 0, rd, er, vis1, low);
        do_req(1, 1'b0, 16'd2, 16'h0, acc2);
        wait_rsp(1, 0, rd2, er, vis2, low);
        check("t6_latency", 32'(vis1 - acc1), 32'd0);
        check("t6_period", 32'(acc2 - acc1), 32'd2);
        check("t6_rdata0", 32'(rd), 32'h00AA);
        check("t6_rdata1", 32'(rd2), 32'h00BB);
        check("t6_busy_cycles", 32'(low), 32'd1);

        rand_traffic(1, 150);

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound in case a handshake never resolves.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, compared=%0d mismatched=%0d", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
